// File: rtl/twiddle_addr_sequencer.sv
// Issues twiddle ROM reads for every stage of one radix-4 FFT frame and carries a
// {valid, stage, last} tag alongside the ROM read latency so the butterfly sees aligned twiddles.
module twiddle_addr_sequencer #(
    parameter int ADDR_W          = 11,
    parameter int NUM_STAGES      = 5,
    parameter int WORDS_PER_STAGE = 256,
    parameter int ROM_LAT         = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              stall_i,
    output logic              rom_valid_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              tw_valid_o,
    output logic [2:0]        tw_stage_o,
    output logic              tw_last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int WW = (WORDS_PER_STAGE > 1) ? $clog2(WORDS_PER_STAGE) : 1;
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
    localparam logic [WW-1:0] LAST_WORD  = WW'(WORDS_PER_STAGE - 1);
    localparam logic [1:0]    LAST_DRAIN = 2'(ROM_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                      state_q, state_d;
    logic [SW-1:0]               stage_q, stage_d;
    logic [WW-1:0]               word_q, word_d;
    logic [1:0]                  drain_q, drain_d;
    logic [ROM_LAT-1:0]          tag_vld_q, tag_vld_d;
    logic [ROM_LAT-1:0][SW-1:0]  tag_stage_q, tag_stage_d;
    logic [ROM_LAT-1:0]          tag_last_q, tag_last_d;

    logic issue;
    logic is_last;

    // An issue is suppressed by abort and reset so no tag for an abandoned frame enters the pipeline.
    assign issue   = (state_q == RUN) && !stall_i && !abort_i && !rst;
    assign is_last = (stage_q == LAST_STAGE) && (word_q == LAST_WORD);

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        word_d  = word_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    stage_d = '0;
                    word_d  = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    if (is_last) begin
                        state_d = DRAIN;
                        stage_d = '0;
                        word_d  = '0;
                        drain_d = '0;
                    end else if (word_q == LAST_WORD) begin
                        word_d  = '0;
                        stage_d = stage_q + SW'(1);
                    end else begin
                        word_d  = word_q + WW'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d = IDLE;
            stage_d = '0;
            word_d  = '0;
            drain_d = '0;
        end
    end

    // Tag pipeline advances every cycle regardless of stall; a stall just shifts in a bubble.
    always_comb begin
        tag_vld_d      = '0;
        tag_stage_d    = '0;
        tag_last_d     = '0;
        tag_vld_d[0]   = issue;
        tag_stage_d[0] = stage_q;
        tag_last_d[0]  = issue && is_last;
        for (int i = 1; i < ROM_LAT; i++) begin
            tag_vld_d[i]   = tag_vld_q[i-1];
            tag_stage_d[i] = tag_stage_q[i-1];
            tag_last_d[i]  = tag_last_q[i-1];
        end
        if (abort_i) begin
            tag_vld_d   = '0;
            tag_stage_d = '0;
            tag_last_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            stage_q     <= '0;
            word_q      <= '0;
            drain_q     <= '0;
            tag_vld_q   <= '0;
            tag_stage_q <= '0;
            tag_last_q  <= '0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            word_q      <= word_d;
            drain_q     <= drain_d;
            tag_vld_q   <= tag_vld_d;
            tag_stage_q <= tag_stage_d;
            tag_last_q  <= tag_last_d;
        end
    end

    // Counters hold during a stall, so the address naturally holds on the pending word.
    assign rom_valid_o = issue;
    assign rom_addr_o  = ADDR_W'(stage_q) * ADDR_W'(WORDS_PER_STAGE) + ADDR_W'(word_q);
    assign tw_valid_o  = tag_vld_q[ROM_LAT-1];
    assign tw_stage_o  = 3'(tag_stage_q[ROM_LAT-1]);
    assign tw_last_o   = tag_last_q[ROM_LAT-1];
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);

endmodule
